// File: rtl/noc_pkg.sv
// Shared packet definitions for the NoC router and its upstream packet generator.
// A packet is {vld, payload[7:0], type[1:0], addr[1:0]}, 13 bits.
package noc_pkg;

  typedef enum logic [1:0] {
    PKT_DATA = 2'b00,
    PKT_CTRL = 2'b01,
    PKT_RESP = 2'b10,
    PKT_RSVD = 2'b11
  } pkt_type_e;

  localparam int PKT_W       = 13;
  localparam int VLD_BIT     = 12;
  localparam int PAYLOAD_MSB = 11;
  localparam int PAYLOAD_LSB = 4;
  localparam int TYPE_MSB    = 3;
  localparam int TYPE_LSB    = 2;
  localparam int ADDR_MSB    = 1;
  localparam int ADDR_LSB    = 0;

  // Assemble one packet from its fields; the valid bit is always set.
  function automatic logic [PKT_W-1:0] make_pkt(input logic [7:0] payload,
                                               input pkt_type_e  ptype,
                                               input logic [1:0] addr);
    logic [PKT_W-1:0] p;
    p                            = '0;
    p[VLD_BIT]                   = 1'b1;
    p[PAYLOAD_MSB:PAYLOAD_LSB]   = payload;
    p[TYPE_MSB:TYPE_LSB]         = ptype;
    p[ADDR_MSB:ADDR_LSB]         = addr;
    return p;
  endfunction

endpackage

// File: rtl/noc_pkt_fifo.sv
// Synchronous FIFO whose head entry is held in an output register, so the
// consumer sees a registered packet. A push into an empty FIFO (or into the
// slot that becomes the head after a pop) is bypassed into the output register
// at the same edge, giving single-cycle latency.
module noc_pkt_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [W-1:0]     head_nxt;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  // Next read pointer, occupancy and head value after this edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (do_pop) rd_ptr_nxt = rd_ptr + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
    // The new head is the word being written when it lands in the head slot.
    head_nxt = (do_push && (rd_ptr_nxt == wr_ptr)) ? din : mem[rd_ptr_nxt];
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is left unreset; occupancy alone decides which words are live.
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and the registered head; the head holds once the FIFO drains.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      if (count_nxt != '0) dout <= head_nxt;
    end
  end

endmodule

// File: rtl/noc_pkt_gen.sv
// Upstream packet generator: round-robin arbiter over the local sources,
// packet assembly, and a small FIFO feeding the router handshake.
module noc_pkt_gen
  import noc_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [8*NUM_SRC-1:0]     src_payload,
  input  logic [2*NUM_SRC-1:0]     src_type,
  output logic [NUM_SRC-1:0]       src_ready,
  output logic [PKT_W-1:0]         packet,
  output logic                     pack_valid,
  input  logic                     nocr_ready,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int RR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [RR_W-1:0]  rr_ptr;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             can_push;
  logic             gnt_any;
  int               gnt_idx;
  logic [PKT_W-1:0] push_pkt;

  assign pack_valid = ~fifo_empty;
  assign pop        = pack_valid & nocr_ready;
  assign can_push   = ~fifo_full | pop;

  // Round-robin search from rr_ptr upward; grant only when the FIFO can take the packet.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = 0;
    src_ready = '0;
    if (reset && can_push) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (!gnt_any && src_valid[(int'(rr_ptr) + k) % NUM_SRC]) begin
          gnt_any = 1'b1;
          gnt_idx = (int'(rr_ptr) + k) % NUM_SRC;
        end
      end
    end
    if (gnt_any) src_ready[gnt_idx] = 1'b1;
  end

  // Packet assembly from the granted source; the addr field is the source index.
  always_comb begin
    push_pkt = make_pkt(src_payload[8*gnt_idx +: 8],
                        pkt_type_e'(src_type[2*gnt_idx +: 2]),
                        2'(gnt_idx));
  end

  // Priority moves to the source after the one just granted.
  always_ff @(posedge clk) begin
    if (!reset) rr_ptr <= '0;
    else if (gnt_any) rr_ptr <= RR_W'((gnt_idx + 1) % NUM_SRC);
  end

  noc_pkt_fifo #(
    .W     (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (gnt_any),
    .din   (push_pkt),
    .pop   (nocr_ready),
    .dout  (packet),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_noc_pkt_gen.sv
// Self-checking bench for noc_pkt_gen: directed scenarios followed by a long
// randomized run, all compared against a queue-based reference model.
module tb_noc_pkt_gen;

  localparam int NUM_SRC = 4;
  localparam int DEPTH   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  src_valid;
  logic [31:0] src_payload;
  logic [7:0]  src_type;
  logic [3:0]  src_ready;
  logic [12:0] packet;
  logic        pack_valid;
  logic        nocr_ready;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [12:0] model_q[$];
  int          model_rr = 0;
  logic [12:0] model_pkt = '0;
  int          last_gnt = -1;

  // Held source requests for the random phase
  bit          req [NUM_SRC];

  noc_pkt_gen #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .src_valid   (src_valid),
    .src_payload (src_payload),
    .src_type    (src_type),
    .src_ready   (src_ready),
    .packet      (packet),
    .pack_valid  (pack_valid),
    .nocr_ready  (nocr_ready),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Which source the model expects to be granted this cycle (-1 for none).
  function automatic int model_grant();
    int  sz;
    bit  room;
    sz   = model_q.size();
    room = (sz < DEPTH) || (sz > 0 && nocr_ready);
    if (!reset || !room) return -1;
    for (int k = 0; k < NUM_SRC; k++) begin
      int idx;
      idx = (model_rr + k) % NUM_SRC;
      if (src_valid[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: check the grant, advance the model at the edge, check the outputs.
  task automatic cycle();
    int          g;
    bit          pop;
    logic [3:0]  exp_rdy;
    logic [12:0] pkt;
    #1;
    g       = model_grant();
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'h0;
    check("src_ready", 32'(src_ready), 32'(exp_rdy));
    pop = reset && (model_q.size() > 0) && nocr_ready;
    pkt = '0;
    if (g >= 0) pkt = {1'b1, src_payload[8*g +: 8], src_type[2*g +: 2], 2'(g)};
    last_gnt = g;
    @(posedge clk);
    if (!reset) begin
      model_q.delete();
      model_rr  = 0;
      model_pkt = '0;
    end else begin
      if (pop) void'(model_q.pop_front());
      if (g >= 0) begin
        model_q.push_back(pkt);
        model_rr = (g + 1) % NUM_SRC;
      end
      if (model_q.size() > 0) model_pkt = model_q[0];
    end
    @(negedge clk);
    check("pack_valid", 32'(pack_valid), 32'(model_q.size() != 0));
    check("fifo_count", 32'(fifo_count), 32'(model_q.size()));
    check("packet", 32'(packet), 32'(model_pkt));
  endtask

  task automatic rand_fields();
    src_payload = $urandom;
    src_type    = 8'($urandom);
  endtask

  initial begin
    reset       = 1'b0;
    src_valid   = 4'hF;
    nocr_ready  = 1'b0;
    rand_fields();

    // 1: reset held two cycles with every source requesting
    cycle();
    cycle();
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_packet", 32'(packet), 32'd0);

    // 2: single source 2, payload A5, type control
    reset       = 1'b1;
    nocr_ready  = 1'b1;
    src_valid   = 4'b0100;
    src_payload = 32'h00A5_0000;
    src_type    = 8'b0001_0000;
    cycle();
    check("t2_packet", 32'(packet), 32'h1A56);
    check("t2_valid", 32'(pack_valid), 32'd1);
    src_valid = 4'h0;
    cycle();
    check("t2_valid_drop", 32'(pack_valid), 32'd0);
    src_valid = 4'hF;
    #1 check("t2_next_gnt", 32'(src_ready), 32'h8);
    cycle();

    // 3: all sources held with the router ready, starting from reset priority
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    rand_fields();
    #1 check("t3_first_gnt", 32'(src_ready), 32'h1);
    for (int i = 0; i < 8; i++) cycle();

    // 4: router stalled until the FIFO fills, then drains
    reset = 1'b0;
    cycle();
    reset      = 1'b1;
    nocr_ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    check("t4_full", 32'(fifo_count), 32'd4);
    #1 check("t4_no_gnt", 32'(src_ready), 32'h0);
    nocr_ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle();

    // 5: full FIFO, pop and push in the same cycle
    nocr_ready = 1'b0;
    rand_fields();
    for (int i = 0; i < 4; i++) cycle();
    src_valid  = 4'b0010;
    nocr_ready = 1'b1;
    #1 check("t5_gnt", 32'(src_ready), 32'h2);
    cycle();
    check("t5_count", 32'(fifo_count), 32'd4);
    src_valid = 4'h0;
    for (int i = 0; i < 5; i++) cycle();

    // 6: reset with three packets queued
    nocr_ready = 1'b0;
    src_valid  = 4'hF;
    for (int i = 0; i < 3; i++) cycle();
    reset = 1'b0;
    cycle();
    check("t6_count", 32'(fifo_count), 32'd0);
    check("t6_valid", 32'(pack_valid), 32'd0);
    reset = 1'b1;
    cycle();
    check("t6_addr", 32'(packet[1:0]), 32'd0);

    // Random phase: sources hold requests until granted, router ready random
    for (int i = 0; i < NUM_SRC; i++) req[i] = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!req[i] && ($urandom_range(1, 0) == 1)) begin
          req[i]               = 1'b1;
          src_payload[8*i +: 8] = 8'($urandom);
          src_type[2*i +: 2]    = 2'($urandom);
        end
        src_valid[i] = req[i];
      end
      nocr_ready = ($urandom_range(3, 0) != 0);
      reset      = ($urandom_range(299, 0) != 0);
      cycle();
      if (last_gnt >= 0) req[last_gnt] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
